sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised FIFO: the next-generation buffer after the dual-clock FIFO, generalised in width and depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a read-valid strobe. It sits between a producer and consumer in the same clock domain and keeps the existing wr/rd error-flag semantics.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_THRESH, DEPTH-2, almost_full_o asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty_o asserts when count ≤ this value (0..DEPTH-1)
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- clear_i  input  1  synchronous flush
- wr_en_i  input  1  write request
- wdata_i  input  WIDTH  write data
- rd_en_i  input  1  read request
- rdata_o  output  WIDTH  read data
- rvalid_o  output  1  rdata_o holds a popped word
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- almost_full_o  output  1  threshold flag
- almost_empty_o  output  1  threshold flag
- count_o  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- wr_error_o  output  1  write attempted while full
- rd_error_o  output  1  read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The count is held separately.
- Write is accepted iff wr_en_i && !full_o. Read is accepted iff rd_en_i && !empty_o. Acceptance uses the registered flags at the edge.
- Simultaneous accepted read and write: both pointers advance and the count is unchanged.
- Simultaneous read and write while full: the read is accepted, the write is rejected, wr_error_o pulses, and the count goes to DEPTH-1.
- Simultaneous read and write while empty: the write is accepted, the read is rejected, rd_error_o pulses, and the count goes to 1. There is no pass-through.
- Errors: wr_error_o = registered (wr_en_i && full_o) and rd_error_o = registered (rd_en_i && empty_o). Each is high for exactly the cycle after the offending edge and is not sticky. Rejected operations change no state.
- clear_i has priority over wr/rd. It zeroes the pointers and count, sets empty_o/almost_empty_o, clears full_o/almost_full_o/rvalid_o, and raises no error. rdata_o holds its value.
- count_o, full_o, empty_o, almost_full_o and almost_empty_o are all registered and computed from the next count, so they are consistent with count_o every cycle.
- Reset values: count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, rvalid_o=0, rdata_o=0, wr_error_o=0, rd_error_o=0. Memory contents are not reset.
- rst_i asserted mid-operation discards all contents immediately (asynchronous). The first accepted write is the edge after rst_i deasserts.

## Timing
- Write latency: a word written at edge N is readable at edge N+1. empty_o falls at edge N.
- Standard mode: rdata_o is registered and loaded at the accepted-read edge N. Data is valid and rvalid_o=1 during cycle N..N+1. rvalid_o is 0 after any non-accepted cycle.
- Flags change at the same edge as the operation that causes them, with no extra cycle.
- Back-to-back reads/writes are sustained at one per clock.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode. rdata_o = mem[rd_ptr] (combinational from the array) and rvalid_o = !empty_o. The head word is visible with no read request. Asserting rd_en_i pops it, and the next word appears after the edge. rdata_o is don't-care while empty.
- SYNC_FIFO_FWFT_EN undefined: standard mode as specified under Timing.
- Flags, count, errors and clear behave identically in both modes.

## Test plan
- Reset then fill: rst_i pulse, then 16 writes of 0x00..0x0F (defaults). Expect count_o 1..16, almost_full_o rising when count_o=14, full_o at count 16, almost_empty_o falling at count 3.
- Overflow/underflow: write while full → wr_error_o=1 for one cycle, count stays 16. Drain 16 words → data 0x00..0x0F in order. Read while empty → rd_error_o=1 for one cycle, count stays 0.
- Simultaneous: at count 5, wr+rd for 20 cycles → count_o stays 5, data in order across the pointer wrap. At full, wr+rd → count 15 and wr_error_o=1. At empty, wr+rd → count 1 and rd_error_o=1.
- Flush: at count 9, clear_i with wr_en_i=1 → count 0, empty_o=1, no error. The next write 0xA5 is read back as 0xA5.
- Mid-operation reset: rst_i asserted between edges at count 7 → outputs reach reset values without a clock edge.
- Mode check: write 0x3C into an empty FIFO. Standard mode: rdata_o=0x3C with rvalid_o=1 only in the cycle after rd_en_i. SYNC_FIFO_FWFT_EN defined: rdata_o=0x3C and rvalid_o=1 one cycle after the write, with no rd_en_i.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO. It provides an occupancy count,
// programmable almost-full/almost-empty thresholds, a synchronous flush,
// a read-valid strobe and one-cycle write/read error pulses.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  When defined, the FIFO runs in first-word-fall-through
//                      mode. rdata_o is the head entry, read straight from the
//                      array, and rvalid_o = !empty_o. When undefined, rdata_o
//                      is a register that loads on each accepted read.
//
// Parameters:
//   WIDTH          data word width (>= 1)
//   DEPTH          number of entries (power of two, >= 2)
//   AFULL_THRESH   almost_full_o  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  almost_empty_o when count <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   clear_i         synchronous flush; takes priority over wr/rd
//   wr_en_i         write request
//   wdata_i         write data
//   rd_en_i         read request
//   rdata_o         read data
//   rvalid_o        rdata_o holds a popped word (standard) / head valid (FWFT)
//   full_o          count == DEPTH
//   empty_o         count == 0
//   almost_full_o   threshold flag
//   almost_empty_o  threshold flag
//   count_o         occupancy, 0..DEPTH
//   wr_error_o      pulses the cycle after a write is attempted while full
//   rd_error_o      pulses the cycle after a read is attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     rvalid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wr_error_o,
    output logic                     rd_error_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance is decided from the registered flags at the edge, so a
    // read and a write on a full FIFO pops only, and on an empty FIFO
    // pushes only.
    always_comb begin
        wr_acc = wr_en_i && !full_o && !clear_i;
        rd_acc = rd_en_i && !empty_o && !clear_i;
    end

    // Next occupancy. Every flag is derived from it, so the flags agree
    // with count_o in every cycle.
    always_comb begin
        count_nxt = count_o;
        if (clear_i) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_o + CW'(1);
                2'b01:   count_nxt = count_o - CW'(1);
                default: count_nxt = count_o;
            endcase
        end
    end

    // Storage array. It has no reset, because stale contents are never
    // observable through the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Count and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            count_o        <= count_nxt;
            full_o         <= (count_nxt == CW'(DEPTH));
            empty_o        <= (count_nxt == '0);
            almost_full_o  <= (count_nxt >= CW'(AFULL_THRESH));
            almost_empty_o <= (count_nxt <= CW'(AEMPTY_THRESH));
        end
    end

    // Error pulses last exactly one cycle. A flush never reports an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            wr_error_o <= wr_en_i && full_o && !clear_i;
            rd_error_o <= rd_en_i && empty_o && !clear_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue is visible without a read request.
    always_comb begin
        rdata_o  = mem[rd_ptr];
        rvalid_o = !empty_o;
    end
`else
    // Registered read port. rdata_o holds its last value through a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= rd_acc;
            if (rd_acc) begin
                rdata_o <= mem[rd_ptr];
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Simulation-only consistency checks.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_o <= CW'(DEPTH))
                else $error("sync_fifo_param: count_o above DEPTH");
            assert (full_o == (count_o == CW'(DEPTH)))
                else $error("sync_fifo_param: full_o inconsistent with count_o");
            assert (empty_o == (count_o == '0))
                else $error("sync_fifo_param: empty_o inconsistent with count_o");
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param with default parameters (8x16,
// almost-full at 14, almost-empty at 2). Inputs change on the falling edge.
// Outputs are sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       wr_error;
    logic       rd_error;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned wval;
    int unsigned rval;
    logic [7:0]  last_rd;

    sync_fifo_param dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .wr_en_i        (wr_en),
        .wdata_i        (wdata),
        .rd_en_i        (rd_en),
        .rdata_o        (rdata),
        .rvalid_o       (rvalid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .wr_error_o     (wr_error),
        .rd_error_o     (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge, returning at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v);
        wr_en = 1'b1;
        wdata = v;
        step();
        wr_en = 1'b0;
    endtask

    // Pop one word and check it in whichever way the build's read port shows it.
    task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, "_fwft_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_fwft_data"}, 32'(rdata), 32'(exp));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_data"}, 32'(rdata), 32'(exp));
`endif
        last_rd = exp;
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        last_rd = '0;

        // Reset values
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_wr_err", 32'(wr_error), 32'd0);
        check("rst_rd_err", 32'(rd_error), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_rdata", 32'(rdata), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
            check("fill_full", 32'(full), 32'((i + 1) == 16));
            check("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
        end

        // Overflow: the error pulses for one cycle and nothing changes
        push(8'hFF);
        check("ovf_wr_err", 32'(wr_error), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        step();
        check("ovf_wr_err_clr", 32'(wr_error), 32'd0);
        check("ovf_count2", 32'(count), 32'd16);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            pop("drain", 8'(i));
            check("drain_count", 32'(count), 32'(15 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        check("idle_rvalid", 32'(rvalid), 32'd0);

        // Underflow
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("udf_rd_err", 32'(rd_error), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        check("udf_rvalid", 32'(rvalid), 32'd0);
        step();
        check("udf_rd_err_clr", 32'(rd_error), 32'd0);

        // Simultaneous read and write at count 5, across the pointer wrap
        wval = 32'h10;
        rval = 32'h10;
        for (int i = 0; i < 5; i++) begin
            push(8'(wval));
            wval++;
        end
        check("sim_pre_count", 32'(count), 32'd5);
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(wval);
`ifdef SYNC_FIFO_FWFT_EN
            check("sim_head", 32'(rdata), 32'(8'(rval)));
            step();
`else
            step();
            check("sim_rdata", 32'(rdata), 32'(8'(rval)));
            check("sim_rvalid", 32'(rvalid), 32'd1);
`endif
            check("sim_count", 32'(count), 32'd5);
            wval++;
            rval++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Fill to full, then read and write together: the read wins
        for (int i = 0; i < 11; i++) begin
            push(8'(wval));
            wval++;
        end
        check("full_pre", 32'(full), 32'd1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hEE;
`ifdef SYNC_FIFO_FWFT_EN
        check("fullrw_head", 32'(rdata), 32'(8'(rval)));
        step();
`else
        step();
        check("fullrw_rdata", 32'(rdata), 32'(8'(rval)));
`endif
        rval++;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("fullrw_count", 32'(count), 32'd15);
        check("fullrw_wr_err", 32'(wr_error), 32'd1);
        check("fullrw_full", 32'(full), 32'd0);
        check("fullrw_afull", 32'(almost_full), 32'd1);
        for (int i = 0; i < 15; i++) begin
            pop("drain2", 8'(rval));
            rval++;
        end
        check("drain2_empty", 32'(empty), 32'd1);

        // Empty FIFO, read and write together: the write wins
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h5A;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_rd_err", 32'(rd_error), 32'd1);
        check("emptyrw_empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        check("emptyrw_rvalid", 32'(rvalid), 32'd1);
`else
        check("emptyrw_rvalid", 32'(rvalid), 32'd0);
`endif
        pop("emptyrw_pop", 8'h5A);

        // Flush at count 9 while writing
        for (int i = 0; i < 9; i++) push(8'(8'h60 + i));
        check("flush_pre", 32'(count), 32'd9);
        clear = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h77;
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_aempty", 32'(almost_empty), 32'd1);
        check("flush_full", 32'(full), 32'd0);
        check("flush_afull", 32'(almost_full), 32'd0);
        check("flush_rvalid", 32'(rvalid), 32'd0);
        check("flush_wr_err", 32'(wr_error), 32'd0);
        check("flush_rd_err", 32'(rd_error), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("flush_rdata_hold", 32'(rdata), 32'(last_rd));
`endif
        push(8'hA5);
        pop("flush_a5", 8'hA5);

        // Asynchronous reset at count 7, between edges
        for (int i = 0; i < 7; i++) push(8'(8'h80 + i));
        check("arst_pre", 32'(count), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_aempty", 32'(almost_empty), 32'd1);
        check("arst_afull", 32'(almost_full), 32'd0);
        check("arst_rvalid", 32'(rvalid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("arst_rdata", 32'(rdata), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        check("arst_hold", 32'(count), 32'd0);

        // Mode check with 0x3C
        push(8'h3C);
`ifdef SYNC_FIFO_FWFT_EN
        check("mode_rvalid", 32'(rvalid), 32'd1);
        check("mode_rdata", 32'(rdata), 32'h3C);
`else
        check("mode_rvalid_pre", 32'(rvalid), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("mode_rvalid", 32'(rvalid), 32'd1);
        check("mode_rdata", 32'(rdata), 32'h3C);
        step();
        check("mode_rvalid_post", 32'(rvalid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
